// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after base, wrapping 3 -> 0.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       base,
    output logic             found,
    output logic [1:0]       idx
);

    logic [N_REQ-1:0] rot;
    logic [1:0]       off;

    always_comb begin
        rot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rot[j] = req[base + 2'(j)];
        end

        // Fixed-priority first-one on the rotated vector; bit 0 is the base index.
        off = 2'd0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = 2'(j);
            end
        end

        found = |rot;
        idx   = base + off;
    end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter owning the sel of a shared 4:1 mux, with a per-tenure hold limit.
module mux4_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       sel,
    output logic             valid
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_t       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid_q, valid_d;

    logic [1:0] base;
    logic       found;
    logic [1:0] win_idx;
    logic       tenure_end;

    // While busy the base is owner+1, which makes the old owner lowest priority on handover.
    assign base = (state_q == IDLE) ? ptr_q : owner_q + 2'd1;

    rr_pick4 u_pick (
        .req   (req),
        .base  (base),
        .found (found),
        .idx   (win_idx)
    );

    assign tenure_end = !req[owner_q] || (hold_cnt_q == HW'(MAX_HOLD));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        valid_d    = valid_q;

        if (state_q == BUSY && !tenure_end) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
            if (state_q == BUSY) begin
                ptr_d = owner_q + 2'd1;
            end
            if (found) begin
                state_d    = BUSY;
                owner_d    = win_idx;
                hold_cnt_d = HW'(1);
                grant_d    = onehot4(win_idx);
                sel_d      = win_idx;
                valid_d    = 1'b1;
            end else begin
                // sel keeps the last owner so the mux output stays stable while idle.
                state_d    = IDLE;
                hold_cnt_d = '0;
                grant_d    = '0;
                valid_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            sel_q      <= 2'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed and randomized checks of mux4_arbiter with hold limits of 8, 2 and 1.
module tb_mux4_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] grant_a, grant_b, grant_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic       valid_a, valid_b, valid_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_arbiter #(.MAX_HOLD(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .req   (req_a),
        .grant (grant_a),
        .sel   (sel_a),
        .valid (valid_a)
    );

    mux4_arbiter #(.MAX_HOLD(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .req   (req_b),
        .grant (grant_b),
        .sel   (sel_b),
        .valid (valid_b)
    );

    mux4_arbiter #(.MAX_HOLD(1)) dut_c (
        .clk   (clk),
        .reset (reset),
        .req   (req_c),
        .grant (grant_c),
        .sel   (sel_c),
        .valid (valid_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic [3:0] eg, input logic [1:0] es,
                              input logic ev);
        check({name, ".grant"}, int'(g), int'(eg));
        check({name, ".sel"}, int'(s), int'(es));
        check({name, ".valid"}, int'(v), int'(ev));
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    // Per-cycle invariants: at most one-hot grant, valid mirrors it, sel names the grantee.
    task automatic check_inv(input string name, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input int hold, input int max_hold);
        logic ok;
        ok = ((g & (g - 4'd1)) == 4'd0) && (v == (|g)) && (!v || g == oh(int'(s)))
             && (!v || (hold >= 1 && hold <= max_hold));
        check(name, int'(ok), 1);
    endtask

    task automatic upd_wait(input string name, input logic [3:0] r, input logic [3:0] g,
                            input int bound, inout int w [4]);
        for (int i = 0; i < 4; i++) begin
            if (r[i] && !g[i]) begin
                w[i]++;
                if (w[i] > bound) begin
                    check({name, ".starve"}, w[i], bound);
                    w[i] = 0;
                end
            end else begin
                w[i] = 0;
            end
        end
    endtask

    vec_t vecs [13];
    int   wait_a [4];
    int   wait_b [4];

    initial begin
        vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[1]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[2]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[3]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[4]  = '{4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[5]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
        vecs[6]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[7]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[9]  = '{4'b0101, 4'b0100, 2'd2, 1'b1};
        vecs[10] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[11] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

        reset = 1'b1;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        tick();
        tick();
        check_outs("reset_a", grant_a, sel_a, valid_a, 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            req_a = vecs[i].req;
            tick();
            check_outs($sformatf("vec%0d", i), grant_a, sel_a, valid_a,
                       vecs[i].grant, vecs[i].sel, vecs[i].valid);
        end

        // Single requester held through two timeouts: continuous grant, counter wraps 8 -> 1.
        req_a = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("hold%0d.grant", k), int'(grant_a), 4);
            check($sformatf("hold%0d.cnt", k), int'(dut_a.hold_cnt_q), ((k - 1) % 8) + 1);
        end

        // Reset in the third cycle of a tenure; first arbitration afterwards uses base 0.
        req_a = 4'b0000;
        tick();
        req_a = 4'b1000;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("pre_rst%0d", k), int'(grant_a), 8);
        end
        reset = 1'b1;
        req_a = 4'b1010;
        tick();
        check_outs("mid_rst", grant_a, sel_a, valid_a, 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        tick();
        check_outs("post_rst", grant_a, sel_a, valid_a, 4'b0010, 2'd1, 1'b1);

        // MAX_HOLD = 2 with everyone requesting: 0,0,1,1,2,2,3,3,0,0,1,1.
        req_b = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_outs($sformatf("rr2_%0d", k), grant_b, sel_b, valid_b,
                       oh((k / 2) % 4), 2'((k / 2) % 4), 1'b1);
        end
        req_b = 4'b0000;

        // MAX_HOLD = 1: rotation every cycle between requesters 0 and 2.
        req_c = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr1_%0d", k), int'(grant_c), (k % 2 == 0) ? 1 : 4);
        end
        req_c = 4'b0000;

        for (int i = 0; i < 4; i++) begin
            wait_a[i] = 0;
            wait_b[i] = 0;
        end
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req_a[i] = ~req_a[i];
                if ($urandom_range(5) == 0) req_b[i] = ~req_b[i];
            end
            tick();
            check_inv("inv_a", grant_a, sel_a, valid_a, int'(dut_a.hold_cnt_q), 8);
            check_inv("inv_b", grant_b, sel_b, valid_b, int'(dut_b.hold_cnt_q), 2);
            upd_wait("rand_a", req_a, grant_a, 3 * 8 + 1, wait_a);
            upd_wait("rand_b", req_b, grant_b, 3 * 2 + 1, wait_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter that shares one 4:1 multiplexed datapath between four requesters. It owns the `sel[1:0]` control of the downstream 4:1 mux and issues a one-hot grant to the winning requester. A per-tenure hold limit stops any single requester from monopolising the path. It sits between the requesting units and the `mux4_1` select input in the CPU datapath.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  request vector; `req[i]` is held high by requester i for as long as it wants the path.
- `grant`  out  4  one-hot (or zero) grant, registered.
- `sel`  out  2  binary index of the current or most recent owner; drives the mux `sel`. Registered.
- `valid`  out  1  high when `grant` is non-zero (`|grant`), registered.

## Operation
- States: IDLE (no owner) and BUSY (owner granted).
- Registered state:
  - `owner[1:0]`
  - `ptr[1:0]`: highest-priority index for the next arbitration.
  - `hold_cnt`: width $clog2(MAX_HOLD+1).
- Arbitration function: scan `req` starting at the base index, wrapping 3→0, and pick the first set bit.
- IDLE:
  - If `req != 0`, pick a winner with base = `ptr`.
  - Next cycle: state BUSY, `grant` = onehot(winner), `sel` = winner, `hold_cnt` = 1.
- BUSY, tenure continues when `req[owner]` = 1 and `hold_cnt` < MAX_HOLD:
  - `grant`, `sel` and `owner` are held.
  - `hold_cnt` increments.
- BUSY, tenure ends when `req[owner]` = 0 (release) or `hold_cnt` == MAX_HOLD (timeout):
  - `ptr` ← owner+1 (mod 4).
  - Re-arbitrate in the same cycle with base = owner+1, so the old owner has lowest priority.
  - If a winner exists, the new grant appears next cycle with `hold_cnt` = 1. This includes re-granting the old owner on timeout when no one else is requesting. There is no bubble cycle.
  - If there is no winner, go to IDLE: `grant` = 0, `valid` = 0.
- `sel` is not cleared when IDLE; it keeps the last owner's value so the mux output stays stable.
- A requester dropping `req` while not granted has no effect.
- A requester raising `req` during another tenure waits; no preemption.

## Timing
- Reset values: `grant` = 4'b0000, `sel` = 2'b00, `valid` = 0, state IDLE, `ptr` = 0, `owner` = 0, `hold_cnt` = 0.
- Reset is synchronous and takes priority over every other event. Reset asserted mid-tenure gives `grant` = 0 on the following edge.
- Latency from `req` rising (arbiter IDLE) to `grant` is 1 cycle.
- Handover on release:
  - Owner drops `req` in cycle n.
  - The next owner's grant is visible in cycle n+1.
  - The old owner's grant is low in cycle n+1.
- Timeout: the owner receives exactly MAX_HOLD consecutive grant cycles before re-arbitration.
- MAX_HOLD = 1: rotation on every cycle among active requesters.
- Invariants:
  - `grant` is at most one-hot.
  - `valid` == `|grant`.
  - When `valid` is high, `sel` == index of `grant`.

## Structure
- Package `arb_pkg`:
  - `N_REQ` = 4.
  - `typedef enum logic {IDLE, BUSY} arb_state_t`.
  - Function `onehot4(idx)`.
- Sub-module `rr_pick4` (combinational): inputs `req[3:0]` and `base[1:0]`; outputs `found` and `idx[1:0]`. Implemented by rotating `req` by `base` and taking a fixed-priority first-one.
- Top level holds the FSM, `hold_cnt`, `ptr` and the output registers.

## Test plan
- Reset then `req` = 4'b0100 → next cycle `grant` = 4'b0100, `sel` = 2, `valid` = 1. Drop `req` → next cycle `grant` = 0, `sel` stays 2.
- `req` = 4'b1111 held continuously with MAX_HOLD = 2 → grant order 0,0,1,1,2,2,3,3,0… with no bubble cycles.
- Owner 1 releases while `req` = 4'b1001 → next owner is 3 (base 2, wrapping forward), not 0.
- Single requester 2 held for 20 cycles with MAX_HOLD = 8 → `grant` stays continuous. `hold_cnt` goes 1..8 and restarts at 1 at cycles 9 and 17.
- `reset` asserted on the 3rd cycle of a tenure → next cycle `grant` = 0, `sel` = 0, `valid` = 0. First arbitration after reset uses base 0.
- Random `req` for 1000 cycles → checks:
  - one-hot invariant and `sel`/`grant` agreement hold throughout;
  - no tenure exceeds MAX_HOLD;
  - every continuously held request is granted within 3·MAX_HOLD+1 cycles.
